// File: rtl/vga_term_ctrl.sv
// Text-terminal controller: owns the COLS x ROWS character memory, turns a byte stream into
// cursor moves and writes, scrolls by rotating the top row, and serves scan-out reads.
module vga_term_ctrl #(
  parameter int unsigned COLS = 70,
  parameter int unsigned ROWS = 30
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_char,
  output logic       in_ready,
  input  logic [6:0] rd_x,
  input  logic [4:0] rd_y,
  output logic [7:0] rd_ascii,
  output logic [6:0] cursor_x,
  output logic [4:0] cursor_y,
  output logic       busy
);

  localparam int unsigned CELLS = COLS * ROWS;

  typedef enum logic [1:0] {StClrAll, StIdle, StClrLine} state_e;

  state_e      r_state;
  logic [11:0] r_cnt;
  logic [6:0]  r_cx;
  logic [4:0]  r_cy;
  logic [4:0]  r_top;
  logic        r_busy;
  logic [7:0]  r_rd;
  logic [7:0]  r_mem [CELLS];

  logic        w_xfer;
  logic        w_printable;
  logic        w_newline;
  logic        w_we;
  logic [11:0] w_waddr;
  logic [7:0]  w_wdata;
  logic [11:0] w_raddr;

  // Screen row -> physical row is a rotation by r_top, wrapped mod ROWS by hand.
  function automatic logic [11:0] cell_addr(input logic [6:0] col, input logic [4:0] row,
                                            input logic [4:0] top);
    logic [5:0] phys;
    phys = {1'b0, row} + {1'b0, top};
    if (phys >= 6'(ROWS)) phys = phys - 6'(ROWS);
    return {6'd0, phys} * 12'(COLS) + {5'd0, col};
  endfunction

  assign w_xfer      = in_valid && (r_state == StIdle);
  assign w_printable = (in_char >= 8'h20) && (in_char <= 8'h7E);
  assign w_newline   = w_xfer && ((in_char == 8'h0A) || (w_printable && r_cx == 7'(COLS - 1)));

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = 8'h20;
    case (r_state)
      StClrAll: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
      end
      StClrLine: begin
        w_we    = 1'b1;
        w_waddr = cell_addr(r_cnt[6:0], 5'(ROWS - 1), r_top);
      end
      StIdle: begin
        if (w_xfer && w_printable) begin
          w_we    = 1'b1;
          w_waddr = cell_addr(r_cx, r_cy, r_top);
          w_wdata = in_char;
        end else if (w_xfer && in_char == 8'h08 && r_cx != 7'd0) begin
          w_we    = 1'b1;
          w_waddr = cell_addr(r_cx - 7'd1, r_cy, r_top);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state <= StClrAll;
      r_cnt   <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_top   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        StClrAll: begin
          if (r_cnt == 12'(CELLS - 1)) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 12'd1;
          end
        end
        StClrLine: begin
          if (r_cnt == 12'(COLS - 1)) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 12'd1;
          end
        end
        StIdle: begin
          if (w_newline) begin
            r_cx <= '0;
            if (r_cy < 5'(ROWS - 1)) begin
              r_cy <= r_cy + 5'd1;
            end else begin
              // Scroll: the old top row becomes the new bottom row and gets blanked.
              r_top   <= (r_top == 5'(ROWS - 1)) ? 5'd0 : r_top + 5'd1;
              r_state <= StClrLine;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end
          end else if (w_xfer && w_printable) begin
            r_cx <= r_cx + 7'd1;
          end else if (w_xfer && in_char == 8'h0D) begin
            r_cx <= '0;
          end else if (w_xfer && in_char == 8'h08 && r_cx != 7'd0) begin
            r_cx <= r_cx - 7'd1;
          end
        end
        default: begin
          r_state <= StClrAll;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign w_raddr = cell_addr(rd_x, rd_y, r_top);

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_rd <= 8'h20;
    end else if (rd_x >= 7'(COLS) || rd_y >= 5'(ROWS)) begin
      r_rd <= 8'h20;
    end else begin
      r_rd <= r_mem[w_raddr];
    end
  end

  assign in_ready = ~r_busy;
  assign busy     = r_busy;
  assign rd_ascii = r_rd;
  assign cursor_x = r_cx;
  assign cursor_y = r_cy;

endmodule
